muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op and state encodings
// plus small op-decode helpers.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply on a 2*WIDTH
// accumulator, or one restoring shift-subtract divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic [WIDTH-1:0]   i_quo,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0]   o_rem,
  output logic [WIDTH-1:0]   o_quo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    // Top bit of the WIDTH+1 difference is the borrow: set means "restore".
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    o_acc    = i_acc;
    o_rem    = i_rem;
    o_quo    = i_quo;
    if (i_is_div) begin
      if (!w_diff[WIDTH]) begin
        o_rem = w_diff[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end else begin
        o_rem = w_rem_sh[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; fixed 34-cycle latency.
// Define MULDIV_MTHI_EN to add the MTHI/MTLO write port (wr_hi, wr_lo, wdata).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MTHI_EN
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             r_state, w_nstate;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_bzero;
  logic [WIDTH-1:0]   r_a_orig, r_opnd, r_rem, r_quo, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  op_e                w_op;
  logic               w_sgn, w_sa, w_sb, w_idle, w_accept;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_acc_nx, w_prod;
  logic [WIDTH-1:0]   w_rem_nx, w_quo_nx, w_quo_s, w_rem_s, w_res_hi, w_res_lo;

  assign w_op     = op_e'(op);
  assign w_sgn    = op_is_signed(w_op);
  assign w_sa     = w_sgn & a[WIDTH-1];
  assign w_sb     = w_sgn & b[WIDTH-1];
  assign w_a_mag  = w_sa ? -a : a;
  assign w_b_mag  = w_sb ? -b : b;
  assign w_idle   = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = start & w_idle;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (start) w_nstate = CALC;
      CALC:    if (r_cnt == LAST) w_nstate = SIGN;
      SIGN:    w_nstate = DONE;
      DONE:    w_nstate = start ? CALC : IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_opnd   (r_opnd),
    .i_is_div (r_is_div),
    .o_acc    (w_acc_nx),
    .o_rem    (w_rem_nx),
    .o_quo    (w_quo_nx)
  );

  // Multiplicand |a| sits in the low half of the accumulator; dividend |a| in quotient.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_orig <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= op_is_div(w_op);
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_bzero  <= (b == '0);
      r_a_orig <= a;
      r_opnd   <= w_b_mag;
      r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
      r_rem    <= '0;
      r_quo    <= w_a_mag;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nx;
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
    end
  end

  assign w_prod  = r_neg_q ? -r_acc : r_acc;
  assign w_quo_s = r_neg_q ? -r_quo : r_quo;
  assign w_rem_s = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_bzero) begin
        w_res_hi = r_a_orig;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem_s;
        w_res_lo = w_quo_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == SIGN) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end
`ifdef MULDIV_MTHI_EN
    else if (w_idle) begin
      if (wr_hi) r_hi <= wdata;
      if (wr_lo) r_lo <= wdata;
    end
`endif
  end

  assign busy = (r_state == CALC) || (r_state == SIGN);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed MIPS corner cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_MTHI_EN
  logic         wr_hi, wr_lo;
  logic [W-1:0] wdata;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MULDIV_MTHI_EN
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} straight from the MIPS semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    longint      sp;
    int          sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: r = {32'b0, x} * {32'b0, y};
      2'b01: begin sp = longint'(sx) * longint'(sy); r = sp; end
      2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0)                                  r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)      r = {32'h0, 32'h8000_0000};
        else                                         r = {32'(sx % sy), 32'(sx / sy)};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at the current cycle (edge 0 is the next edge); return in cycle 34.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int ign_k, input string tag);
    logic [63:0] e;
    int          nbad;
    e     = model(o, x, y);
    nbad  = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) nbad++;
      if (k == ign_k) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
`ifdef MULDIV_MTHI_EN
        wr_hi = 1'b1; wdata = $urandom;
`endif
      end else if (ign_k != 0 && k == ign_k + 1) begin
        start = 1'b0;
`ifdef MULDIV_MTHI_EN
        wr_hi = 1'b0;
`endif
      end
      @(posedge clk); #1;
    end
    check({tag, ":busy_window"}, 64'(nbad), 64'd0);
    check({tag, ":busy_done"}, {62'b0, busy, done}, 64'b01);
    check({tag, ":hilo"}, {hi, lo}, e);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic settle(input string tag);
    @(posedge clk); #1;
    check({tag, ":idle"}, {62'b0, busy, done}, 64'b00);
    check({tag, ":hold"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  task automatic reset_abort();
    int nd;
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h8765_4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort:busy_done", {62'b0, busy, done}, 64'b00);
    check("abort:hilo", {hi, lo}, 64'h0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 0 || lo !== 0) nd++;
    end
    check("abort:quiet", 64'(nd), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef MULDIV_MTHI_EN
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset:busy_done", {62'b0, busy, done}, 64'b00);
    check("reset:hilo", {hi, lo}, 64'h0);

    run(2'b00, 32'hFFFF_FFFF, 32'd2, 0, "multu");       settle("multu");
    run(2'b01, 32'hFFFF_FFFD, 32'd5, 0, "mult");        settle("mult");
    run(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "div");         settle("div");
    run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf"); settle("div_ovf");
    run(2'b10, 32'd7, 32'd0, 0, "divu_by0");            settle("divu_by0");
    run(2'b11, 32'hFFFF_FFF9, 32'd0, 5, "div_by0_ign"); settle("div_by0_ign");

    reset_abort();

    run(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, "b2b_first");
    run(2'b10, 32'hFFFF_FFFF, 32'h10, 0, "b2b_second");
    settle("b2b");

`ifdef MULDIV_MTHI_EN
    wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    check("mtlo", {hi, lo}, {exp_hi, exp_lo});
    wr_hi = 1'b1; wdata = 32'h0BAD_BEEF;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    exp_hi = 32'h0BAD_BEEF;
    check("mthi", {hi, lo}, {exp_hi, exp_lo});
    run(2'b00, 32'd3, 32'd4, 3, "mthi_busy_ign");
    settle("mthi_busy_ign");
`endif

    for (int i = 0; i < 40; i++) begin
      run(2'($urandom), pick(), pick(), (i % 4 == 0) ? 5 : 0, "rand");
      if (i % 3 == 0) settle("rand");
    end
    settle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
